// File: rtl/frac_mul_seq_pkg.sv
// Shared widths, iteration count and digit encoding for the radix-4 fractional multiplier.
// Also holds the Q1.63 -> Q1.31 round-half-up helper with saturation.
package frac_mul_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
  localparam int ACC_W  = 34;
  localparam int ITER   = 16;
  localparam int CNT_W  = 5;

  localparam logic [1:0] DIG_ZERO  = 2'd0;
  localparam logic [1:0] DIG_ONE   = 2'd1;
  localparam logic [1:0] DIG_TWO   = 2'd2;
  localparam logic [1:0] DIG_THREE = 2'd3;

  // Adds the half-LSB bit to the upper word and clamps instead of wrapping past all-ones.
  function automatic logic [OP_W-1:0] round_q131(input logic [PROD_W-1:0] prod);
    logic [OP_W:0] inc;
    inc = {1'b0, prod[PROD_W-1:OP_W]} + {{OP_W{1'b0}}, prod[OP_W-1]};
    round_q131 = inc[OP_W] ? {OP_W{1'b1}} : inc[OP_W-1:0];
  endfunction

endpackage

// File: rtl/frac_mul_seq_if.sv
// Start/busy/ready/count handshake bundle shared with the iterative divider.
// The controller side drives operands and start; the multiplier returns results and status.
interface frac_mul_seq_if;
  import frac_mul_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [PROD_W-1:0] p;
  logic [OP_W-1:0]   r;
  logic              busy;
  logic              ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output start, a, b,
    input  p, r, busy, ready, count
  );

  modport slave (
    input  start, a, b,
    output p, r, busy, ready, count
  );

endinterface

// File: rtl/frac_mul_seq_radix4_pp_select.sv
// Radix-4 partial product mux: picks 0, a, 2a or 3a for one multiplier digit.
// 3a is supplied precomputed so this stays a pure selector.
module radix4_pp_select
  import frac_mul_pkg::*;
(
  input  logic [1:0]       digit,
  input  logic [OP_W-1:0]  a_x1,
  input  logic [ACC_W-1:0] a_x3,
  output logic [ACC_W-1:0] pp
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] a_x2;

  assign a_ext = {2'b00, a_x1};
  assign a_x2  = {1'b0, a_x1, 1'b0};

  always_comb begin
    pp = '0;
    case (digit)
      DIG_ZERO:  pp = '0;
      DIG_ONE:   pp = a_ext;
      DIG_TWO:   pp = a_x2;
      DIG_THREE: pp = a_x3;
      default:   pp = '0;
    endcase
  end

endmodule

// File: rtl/frac_mul_seq.sv
// Sequential radix-4 unsigned fractional multiplier: Q1.31 x Q0.32 -> exact Q1.63 plus rounded Q1.31.
// Retires two multiplier bits per cycle over 16 iterations behind the divider-style handshake.
module frac_mul_seq
  import frac_mul_pkg::*;
(
  input logic           clk,
  input logic           clrn,
  frac_mul_seq_if.slave bus
);

  logic [ACC_W-1:0] hi;
  logic [OP_W-1:0]  lo;
  logic [OP_W-1:0]  a_q;
  logic [ACC_W-1:0] a3_q;
  logic             busy_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic [ACC_W-1:0]  pp;
  logic [ACC_W-1:0]  sum;
  logic [PROD_W-1:0] prod;
  logic              hi_ovf;

  radix4_pp_select u_pp_select (
    .digit (lo[1:0]),
    .a_x1  (a_q),
    .a_x3  (a3_q),
    .pp    (pp)
  );

  // hi stays below 2^32 after every shift, so this sum never overflows 34 bits.
  assign sum = hi + pp;

  // Reset beats start; a start in any state reloads, aborting a product in flight.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      hi      <= '0;
      lo      <= '0;
      a_q     <= '0;
      a3_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.start) begin
      hi      <= '0;
      lo      <= bus.b;
      a_q     <= bus.a;
      a3_q    <= {2'b00, bus.a} + {1'b0, bus.a, 1'b0};
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else if (busy_q) begin
      hi    <= {2'b00, sum[ACC_W-1:2]};
      lo    <= {sum[1:0], lo[OP_W-1:2]};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(ITER - 1)) begin
        busy_q  <= 1'b0;
        ready_q <= 1'b1;
      end
    end
  end

  assign prod   = {hi[OP_W-1:0], lo};
  assign hi_ovf = |hi[ACC_W-1:OP_W];

  // hi_ovf is structurally zero; folding it into the clamp keeps r saturating rather than truncating.
  assign bus.p     = prod;
  assign bus.r     = hi_ovf ? {OP_W{1'b1}} : round_q131(prod);
  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.count = cnt_q;

endmodule

// File: tb/tb_frac_mul_seq.sv
// Self-checking bench for frac_mul_seq: vector table, restart/reset corner cases and a random sweep.
// Expected products come from a 64-bit reference multiply and a scoreboard queue.
module tb_frac_mul_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [63:0] p;
    logic [31:0] r;
  } exp_t;

  logic clk;
  logic clrn;
  int   n_pass;
  int   n_total;
  exp_t sb[$];
  vec_t vecs[7];

  frac_mul_seq_if bus ();

  frac_mul_seq dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_round(input logic [63:0] prod);
    logic [31:0] upper;
    upper = prod[63:32];
    if (prod[31] && upper != 32'hFFFF_FFFF) return upper + 32'd1;
    return upper;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drives start for one edge at a negedge and records the expected result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    e.p = prod;
    e.r = ref_round(prod);
    sb.push_back(e);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("ready_after_start", 64'(bus.ready), 64'd0);
    check("count_after_start", 64'(bus.count), 64'd0);
  endtask

  task automatic checkOutput(input string name);
    int cyc = 0;
    int busy_cyc = 0;
    exp_t e;
    while (!bus.ready && cyc < 40) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd16);
    check({name, "_busy_cycles"}, 64'(busy_cyc), 64'd16);
    check({name, "_count_done"}, 64'(bus.count), 64'd16);
    check({name, "_busy_done"}, 64'(bus.busy), 64'd0);
    if (sb.size() == 0) begin
      check({name, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({name, "_p"}, bus.p, e.p);
      check({name, "_r"}, 64'(bus.r), 64'(e.r));
    end
  endtask

  task automatic waitCount(input logic [4:0] target);
    int guard = 0;
    while (bus.count != target && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("wait_count", 64'(bus.count), 64'(target));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32'h4000_0000};
    vecs[1] = '{32'h0000_0001, 32'h8000_0000, 64'h0000_0000_8000_0000, 32'h0000_0001};
    vecs[2] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 32'h0000_0000};
    vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 32'h0000_0001};
    vecs[5] = '{32'h0001_0000, 32'h0000_8000, 64'h0000_0000_8000_0000, 32'h0000_0001};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE};

    clrn = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_count", 64'(bus.count), 64'd0);
    check("reset_p", bus.p, 64'd0);
    check("reset_r", 64'(bus.r), 64'd0);
    clrn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      vec_t v;
      exp_t e;
      v = vecs[i];
      applyStimulus(v.a, v.b);
      e = sb[sb.size() - 1];
      check($sformatf("vec%0d_model_p", i), e.p, v.p);
      checkOutput($sformatf("vec%0d", i));
      check($sformatf("vec%0d_table_p", i), bus.p, v.p);
      check($sformatf("vec%0d_table_r", i), 64'(bus.r), 64'(v.r));
    end

    // Last vector is the max-operand case: result must hold through idle cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.ready), 64'd1);
      check("hold_p", bus.p, 64'hFFFF_FFFE_0000_0001);
      check("hold_count", 64'(bus.count), 64'd16);
    end

    // Restart mid-operation: first product is abandoned, no ready for it.
    applyStimulus(32'h3, 32'h5);
    waitCount(5'd7);
    void'(sb.pop_back());
    applyStimulus(32'h10, 32'h10);
    checkOutput("restart");
    check("restart_p_const", bus.p, 64'h100);

    // Reset in the middle of a run.
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
    waitCount(5'd5);
    void'(sb.pop_back());
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_ready", 64'(bus.ready), 64'd0);
    check("midreset_count", 64'(bus.count), 64'd0);
    check("midreset_p", bus.p, 64'd0);
    check("midreset_r", 64'(bus.r), 64'd0);

    // Reset together with start: reset wins.
    clrn = 1'b0;
    bus.start = 1'b1;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'hFFFF_FFFF;
    @(negedge clk);
    clrn = 1'b1;
    bus.start = 1'b0;
    check("rst_start_busy", 64'(bus.busy), 64'd0);
    check("rst_start_ready", 64'(bus.ready), 64'd0);
    check("rst_start_count", 64'(bus.count), 64'd0);
    check("rst_start_p", bus.p, 64'd0);
    repeat (3) @(negedge clk);
    check("rst_start_idle_busy", 64'(bus.busy), 64'd0);

    applyStimulus(32'hC000_0000, 32'h4000_0000);
    checkOutput("post_reset");

    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom, $urandom);
      checkOutput("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
